// File: rtl/gaming_led_array_if.sv
// Pin-level bundle for the gaming LED array: control inputs from the board
// logic and the registered LED/step outputs.
interface gaming_led_array_if #(
    parameter int NUM_LEDS = 1,
    parameter int PWM_BITS = 8
);
    logic                    iENABLE;
    logic [1:0]              iMODE;
    logic [3*PWM_BITS-1:0]   iSTATIC_RGB;
    logic [3*NUM_LEDS-1:0]   oLED;
    logic                    oSTEP;

    modport master (output iENABLE, iMODE, iSTATIC_RGB, input oLED, oSTEP);
    modport slave  (input iENABLE, iMODE, iSTATIC_RGB, output oLED, oSTEP);
endinterface

// File: rtl/gaming_led_array.sv
// Multi-LED RGB driver: phase-offset triangle colour wheel, static/breathe/off
// modes, per-colour dimming and frame-buffered PWM duty.
module gaming_led_array #(
    parameter int NUM_LEDS   = 1,
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 60000,
    parameter int LED_OFFSET = 128,
    parameter int R_SHIFT    = 1,
    parameter int G_SHIFT    = 3,
    parameter int B_SHIFT    = 0,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    gaming_led_array_if.slave  bus
);
    localparam int PW    = PWM_BITS;
    localparam int M     = 1 << PWM_BITS;
    localparam int BW    = PWM_BITS + 3;
    localparam int NCH   = 3 * NUM_LEDS;
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [BW-1:0]        BASE_LAST = BW'(6 * M - 1);
    localparam logic [BW:0]          SIX_M     = (BW + 1)'(6 * M);
    localparam logic [BW-1:0]        M_U       = BW'(M);
    localparam logic [BW-1:0]        TWO_M_U   = BW'(2 * M);
    localparam logic [BW-1:0]        FOUR_M_U  = BW'(4 * M);
    localparam logic signed [BW-1:0] TWO_M_S   = BW'(2 * M);
    localparam logic signed [BW-1:0] MAX_S     = BW'(M - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BW-1:0]    base_q, base_d;
    logic             step_q, step_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    t_q [NCH];
    logic [PW-1:0]    t_d [NCH];
    logic [PW-1:0]    a_q [NCH];
    logic [PW-1:0]    a_d [NCH];
    logic [NCH-1:0]   led_q, led_d;
    logic [PW-1:0]    level;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    stat;

    // Channel index b: 2 = R, 1 = G, 0 = B (matches pin and static-colour order).
    function automatic logic [BW-1:0] chan_phase(input logic [BW-1:0] base, input int k, input int b);
        logic [BW:0] off;
        logic [BW:0] s;
        off = (BW + 1)'((k * LED_OFFSET + (2 - b) * 2 * M) % (6 * M));
        s   = {1'b0, base} + off;
        if (s >= SIX_M) s = s - SIX_M;
        return s[BW-1:0];
    endfunction

    function automatic logic [PW-1:0] tri_duty(input logic [BW-1:0] p);
        logic signed [BW-1:0] d;
        d = TWO_M_S - $signed(p);
        if (d[BW-1]) d = -d;
        d = TWO_M_S - d;
        if (d[BW-1]) return '0;
        if (d > MAX_S) return '1;
        return d[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] breathe_level(input logic [BW-1:0] base);
        logic [BW-1:0] q;
        q = base;
        if (q >= FOUR_M_U)     q = q - FOUR_M_U;
        else if (q >= TWO_M_U) q = q - TWO_M_U;
        if (q < M_U) return q[PW-1:0];
        return PW'(TWO_M_U - BW'(1) - q);
    endfunction

    function automatic logic [PW-1:0] breathe_duty(input logic [PW-1:0] s, input logic [PW-1:0] l);
        logic [2*PW-1:0] prod;
        prod = {{PW{1'b0}}, s} * {{PW{1'b0}}, l};
        return PW'(prod >> PW);
    endfunction

    function automatic int dim_shift(input int b);
        return (b == 2) ? R_SHIFT : ((b == 1) ? G_SHIFT : B_SHIFT);
    endfunction

    always_comb begin
        div_d  = div_q;
        base_d = base_q;
        step_d = 1'b0;
        cnt_d  = cnt_q + 1'b1;
        level  = breathe_level(base_q);
        sel    = '0;
        stat   = '0;
        led_d  = '0;

        // Stage 0: phase divider and base phase
        if (bus.iENABLE) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                step_d = 1'b1;
                base_d = (base_q == BASE_LAST) ? '0 : base_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        // Stage 1: target duty, then active duty latched at the frame wrap
        for (int k = 0; k < NUM_LEDS; k++) begin
            for (int b = 0; b < 3; b++) begin
                stat = bus.iSTATIC_RGB[b*PW +: PW];
                case (bus.iMODE)
                    2'd0:    sel = tri_duty(chan_phase(base_q, k, b));
                    2'd1:    sel = stat;
                    2'd2:    sel = breathe_duty(stat, level);
                    default: sel = '0;
                endcase
                t_d[3*k+b]   = sel >> dim_shift(b);
                a_d[3*k+b]   = (cnt_q == '1) ? t_q[3*k+b] : a_q[3*k+b];
                led_d[3*k+b] = (cnt_q < a_q[3*k+b]) ^ ACTIVE_LOW;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            div_q  <= '0;
            base_q <= '0;
            step_q <= 1'b0;
            cnt_q  <= '0;
            led_q  <= {NCH{ACTIVE_LOW}};
            for (int j = 0; j < NCH; j++) begin
                t_q[j] <= '0;
                a_q[j] <= '0;
            end
        end else begin
            div_q  <= div_d;
            base_q <= base_d;
            step_q <= step_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            for (int j = 0; j < NCH; j++) begin
                t_q[j] <= t_d[j];
                a_q[j] <= a_d[j];
            end
        end
    end

    assign bus.oLED  = led_q;
    assign bus.oSTEP = step_q;
endmodule
